// File: rtl/exbytes_pkg.sv
// Shared exbus definitions: word layout, special-word code and byte framing.
package exbytes_pkg;

    localparam int unsigned EXB_WORD_W = 35;
    localparam int unsigned EXB_CHUNK  = 7;
    localparam int unsigned EXB_NBYTES = 5;
    localparam int unsigned EXB_CNT_W  = 3;

    localparam logic [1:0] EXB_SPECIAL = 2'b11;
    localparam logic       EXB_SOW     = 1'b1;

    localparam logic [EXB_CNT_W-1:0] EXB_CNT_FULL = EXB_CNT_W'(EXB_NBYTES - 1);

    function automatic logic exb_is_special(input logic [EXB_WORD_W-1:0] word);
        return word[EXB_WORD_W-1 -: 2] == EXB_SPECIAL;
    endfunction

    // Number of bytes still to follow once the first byte of this word is out.
    function automatic logic [EXB_CNT_W-1:0] exb_tail_count(input logic [EXB_WORD_W-1:0] word);
        return exb_is_special(word) ? '0 : EXB_CNT_FULL;
    endfunction

endpackage

// File: rtl/exbytes.sv
// Exbus word-to-byte serialiser: 35-bit words out as 7-bit chunks, MS first,
// with a start-of-word marker in bit 7 of each word's first byte.
module exbytes
    import exbytes_pkg::*;
#(
    parameter logic OPT_LOWPOWER = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stb,
    input  logic [EXB_WORD_W-1:0] i_word,
    output logic                  o_busy,
    output logic                  o_stb,
    output logic [7:0]            o_byte,
    input  logic                  i_busy,
    output logic                  o_active
);

    logic [EXB_WORD_W-1:0] sreg_q;
    logic [EXB_CNT_W-1:0]  count_q;
    logic                  stb_q;
    logic [7:0]            byte_q;

    logic busy;
    logic accept;
    logic advance;
    logic more;

    assign more    = count_q != '0;
    assign busy    = stb_q && (more || i_busy);
    assign accept  = i_stb && !busy;
    assign advance = stb_q && !i_busy;

    // Implicit FSM in {stb_q, count_q}: idle, sending (count>0), last byte (count==0).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sreg_q  <= '0;
            count_q <= '0;
            stb_q   <= 1'b0;
            byte_q  <= '0;
        end else if (accept) begin
            sreg_q  <= i_word;
            count_q <= exb_tail_count(i_word);
            stb_q   <= 1'b1;
            byte_q  <= {EXB_SOW, i_word[EXB_WORD_W-1 -: EXB_CHUNK]};
        end else if (advance) begin
            if (more) begin
                sreg_q  <= sreg_q << EXB_CHUNK;
                count_q <= count_q - 1'b1;
                byte_q  <= {~EXB_SOW, sreg_q[EXB_WORD_W-1-EXB_CHUNK -: EXB_CHUNK]};
            end else begin
                stb_q <= 1'b0;
            end
        end
    end

    always_comb begin
        o_busy   = busy;
        o_stb    = stb_q;
        o_active = stb_q;
        o_byte   = (OPT_LOWPOWER && !stb_q) ? 8'h00 : byte_q;
    end

endmodule
